// File: rtl/uart_pkg.sv
// Shared UART definitions: sequencer state encoding, data-width floor and frame timing.
// Used by the TX frame sequencer and intended for the matching RX sequencer.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned MIN_DATA_BITS = 5;

  // Frame length in counter ticks: start + data + optional parity + 1 or 2 stop bits.
  function automatic int unsigned frame_ticks(input int unsigned oversample,
                                              input int unsigned data_bits,
                                              input logic        parity_en,
                                              input logic        stop2);
    return oversample * (32'd2 + data_bits + 32'(parity_en) + 32'(stop2));
  endfunction

endpackage

// File: rtl/uart_tick_counter.sv
// Modulo-OVERSAMPLE tick counter; wrap_o pulses combinationally on the tick that ends a bit.
// Counts only while en_i and a tick is present; clr_i restarts at zero and wins over counting.
module uart_tick_counter #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic areset_n,
  input  logic clr_i,
  input  logic en_i,
  input  logic tick_i,
  output logic wrap_o
);

  localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign wrap_o = en_i && tick_i && (cnt_q == CW'(OVERSAMPLE - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && tick_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame_seq.sv
// UART TX frame sequencer: start, 5..DATA_W data bits LSB first, optional parity, 1-2 stops.
// Line moves the cycle after the deciding tick; tx_en is dropped unless idle or on the done cycle.
module uart_tx_frame_seq
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                      clk,
  input  logic                      areset_n,
  input  logic                      tx_en,
  input  logic [DATA_W-1:0]         tx_data,
  input  logic [3:0]                data_bits,
  input  logic                      parity_en,
  input  logic                      parity_odd,
  input  logic                      stop2,
  input  logic                      counter_tick,
  output logic                      tx,
  output logic [$clog2(DATA_W)-1:0] sel,
  output logic                      busy,
  output logic                      done
);

  localparam int SW = $clog2(DATA_W);

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [SW-1:0]     n_q, n_d;
  logic [3:0]        nbits_q, nbits_d;
  logic              par_en_q, par_en_d;
  logic              par_q, par_d;
  logic              stop2_q, stop2_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              tx_q, tx_d;

  logic              bit_end;
  logic              accept;
  logic [3:0]        nb_clamp;
  logic [DATA_W-1:0] mask;

  uart_tick_counter #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick_cnt (
    .clk     (clk),
    .areset_n(areset_n),
    .clr_i   (accept),
    .en_i    (busy),
    .tick_i  (counter_tick),
    .wrap_o  (bit_end)
  );

  assign busy = (state_q != ST_IDLE);
  assign tx   = tx_q;
  assign sel  = (state_q == ST_DATA) ? n_q : '0;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    n_d        = n_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    stop_cnt_d = stop_cnt_q;
    done       = 1'b0;
    accept     = 1'b0;
    tx_d       = 1'b1;

    // Out-of-range widths are clamped so the frame length is always well defined.
    nb_clamp = data_bits;
    if (data_bits > 4'(DATA_W)) begin
      nb_clamp = 4'(DATA_W);
    end else if (data_bits < 4'(MIN_DATA_BITS)) begin
      nb_clamp = 4'(MIN_DATA_BITS);
    end
    mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      mask[i] = (i < int'(nb_clamp));
    end

    case (state_q)
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          n_d     = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (4'(n_q) == nbits_q - 4'd1) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            shift_d = shift_q >> 1;
            n_d     = n_q + SW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == stop2_q) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    accept = tx_en && ((state_q == ST_IDLE) || done);
    if (accept) begin
      state_d    = ST_START;
      shift_d    = tx_data & mask;
      nbits_d    = nb_clamp;
      par_en_d   = parity_en;
      par_d      = (^(tx_data & mask)) ^ parity_odd;
      stop2_d    = stop2;
      stop_cnt_d = 1'b0;
    end

    // Line level follows the state being entered, so tx stays registered.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_q;
      default:   tx_d = 1'b1;
    endcase
    if (accept) begin
      tx_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      n_q        <= '0;
      nbits_q    <= '0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      n_q        <= n_d;
      nbits_q    <= nbits_d;
      par_en_q   <= par_en_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
    end
  end

endmodule
